// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the canonical bubble word
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// A flush replaces the instruction with a bubble but keeps the PC fields.
// A flush takes priority over a stall (en low).
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   flush,
  input  if_id_t dIn,
  output if_id_t q
);

  // Register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr   <= BUBBLE_INSTR;
      q.pc      <= '0;
      q.pcPlus4 <= '0;
      q.valid   <= 1'b0;
    end else if (flush) begin
      q.instr <= BUBBLE_INSTR;
      q.valid <= 1'b0;
    end else if (en) begin
      q <= dIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// This module holds the PC and the startup FSM.
// It drives the instruction-memory address and registers the fetched word into IF/ID.
module fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcE,
  input  logic [31:0] pcTargetE,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        misalignErr
);

  riscv_pkg::fetch_state_t state, nextState;
  logic [31:0]       pcF, pcNext, pcF4;
  riscv_pkg::if_id_t ifIdIn, ifIdQ;
  logic              inHold;

  assign pcF4     = pcF + 32'd4;
  assign inHold   = (state == riscv_pkg::HOLD);
  assign imemAddr = pcF;

  // Startup FSM state register: one idle cycle after reset, then run forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= riscv_pkg::HOLD;
    else        state <= nextState;
  end

  // Next-state logic: HOLD always advances, RUN is terminal.
  always_comb begin
    nextState = state;
    case (state)
      riscv_pkg::HOLD: nextState = riscv_pkg::RUN;
      riscv_pkg::RUN:  nextState = riscv_pkg::RUN;
      default:         nextState = riscv_pkg::HOLD;
    endcase
  end

  // Next PC: a redirect beats a stall, and the target is forced word-aligned.
  always_comb begin
    pcNext = pcF;
    if (inHold)       pcNext = pcF;
    else if (pcSrcE)  pcNext = {pcTargetE[31:2], 2'b00};
    else if (!stallF) pcNext = pcF4;
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcF <= RESET_PC;
    else        pcF <= pcNext;
  end

  // Sticky misaligned-redirect flag. It is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             misalignErr <= 1'b0;
    else if (pcSrcE && (pcTargetE[1:0] != 2'b00)) misalignErr <= 1'b1;
  end

  // Word presented to IF/ID when it is allowed to capture.
  always_comb begin
    ifIdIn.instr   = imemRdata;
    ifIdIn.pc      = pcF;
    ifIdIn.pcPlus4 = pcF4;
    ifIdIn.valid   = 1'b1;
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!stallD),
    .flush(flushD || inHold),
    .dIn  (ifIdIn),
    .q    (ifIdQ)
  );

  assign instrD   = ifIdQ.instr;
  assign pcD      = ifIdQ.pc;
  assign pcPlus4D = ifIdQ.pcPlus4;
  assign validD   = ifIdQ.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined RV32I core: holds the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. Its `instrD` output feeds the decode stage directly, including the immediate extender, which slices `instrD`. The stage accepts stall and flush controls from the hazard unit and branch/jump redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013 (`addi x0,x0,0`), bubble word placed in `instrD`.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stallF`  in  1  hold `PCF`.
- `stallD`  in  1  hold the IF/ID register.
- `flushD`  in  1  replace the IF/ID contents with a bubble.
- `pcSrcE`  in  1  redirect PC to `pcTargetE`.
- `pcTargetE`  in  32  branch/jump target from execute.
- `imemAddr`  out  32  instruction-memory address; equals `PCF`.
- `imemRdata`  in  32  instruction word; combinational read of `imemAddr`.
- `instrD`  out  32  registered instruction for decode.
- `pcD`  out  32  PC of `instrD`.
- `pcPlus4D`  out  32  `pcD + 4`.
- `validD`  out  1  `instrD` is a real fetched instruction.
- `misalignErr`  out  1  sticky flag: a redirect target had nonzero bits [1:0].

## Operation
- Internal state is `PCF` (32 bits) plus a 2-state FSM: `HOLD` and `RUN`.
  - Reset forces `HOLD`.
  - `HOLD` moves to `RUN` unconditionally after one clock.
  - `RUN` is terminal until the next reset.
- PC update, priority high to low, at each rising edge:
  - `state==HOLD`: `PCF` unchanged.
  - `pcSrcE`: `PCF <= {pcTargetE[31:2],2'b00}`. The redirect overrides `stallF`.
  - `!stallF`: `PCF <= PCF + 4`. The add is 32-bit and wraps modulo 2^32, so 32'hFFFF_FFFC + 4 gives 0.
  - Otherwise `PCF` holds.
- IF/ID update, priority high to low:
  - `flushD` or `state==HOLD`: `instrD <= NOP_INSTR`, `validD <= 0`. `pcD` and `pcPlus4D` are unchanged. Flush overrides `stallD`.
  - `!stallD`: `instrD <= imemRdata`, `pcD <= PCF`, `pcPlus4D <= PCF+4`, `validD <= 1`.
  - Otherwise all IF/ID fields hold.
- `misalignErr` is set on any edge where `pcSrcE && pcTargetE[1:0]!=0`, regardless of stalls. It is cleared only by reset.
- Reset (asynchronous, possible mid-operation):
  - `PCF=RESET_PC`, `instrD=NOP_INSTR`, `pcD=0`, `pcPlus4D=0`, `validD=0`, `misalignErr=0`, state `HOLD`.
  - `imemAddr=RESET_PC` immediately, without waiting for a clock edge.
- No handshake with memory: `imemRdata` is valid in the same cycle as `imemAddr`.

## Timing
- Fetch latency is one cycle: the word at `PCF` in cycle n appears on `instrD` in cycle n+1.
- After `rst_n` rises:
  - First edge: state moves to `RUN`; `PCF` stays at `RESET_PC`; a bubble is loaded.
  - Second edge: the instruction at `RESET_PC` is loaded with `validD=1`; `PCF` becomes `RESET_PC+4`.
- Redirect seen at edge k:
  - `PCF=target` after edge k.
  - The target instruction appears on `instrD` after edge k+1.
  - The hazard unit asserts `flushD` alongside `pcSrcE` to kill the wrong-path word. This block does not couple them internally.
- `stallF=1` together with `stallD=1`: `imemAddr`, `instrD`, `pcD` and `validD` are all frozen across the edge.
- `stallD=1` with `stallF=0` is not a legal hazard-unit combination. The block still follows the rules above: the PC advances and the word is lost.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN=32`.
  - `NOP_INSTR` constant.
  - `fetch_state_t` enum (`HOLD`, `RUN`).
  - `if_id_t` struct (`instr`, `pc`, `pcPlus4`, `valid`).
- One sub-module, `if_id_reg`: the IF/ID pipeline register with enable, flush and asynchronous active-low reset. The PC register, FSM and misalignment flag stay in `fetch_stage`.

## Test plan
- Reset release, `imemRdata = imemAddr` pattern, no stalls:
  - `validD=0` for one cycle after the first edge.
  - Then `pcD` reads 0, 4, 8; `pcPlus4D` reads 4, 8, 12; `instrD` tracks the pattern.
- `stallF=stallD=1` for 3 cycles while `PCF=8`: `imemAddr` stays 8, `instrD` and `pcD` stay at PC 4, `validD` stays 1.
- Redirect:
  - Stimulus: `pcSrcE=1`, `flushD=1`, `pcTargetE=32'h100`, `stallF=1`.
  - Response: `PCF=0x100` next cycle and `instrD=NOP_INSTR` with `validD=0`; the following cycle `pcD=0x100`, `validD=1`.
- Misaligned target `32'h102`: `PCF=0x100` and `misalignErr=1`, which stays set until `rst_n` is asserted.
- Simultaneous `flushD=1`, `stallD=1`: bubble loaded (`validD=0`, `instrD=32'h13`).
- `rst_n` asserted mid-run with `PCF=0x40`: outputs are at reset values without waiting for a clock edge; `imemAddr=RESET_PC`.
- PC wrap: starting from `PCF=32'hFFFF_FFFC` with no stall, the next `PCF=0`.
